img_loader: RTL and testbench

Frame-store writer for the VGA image path. Accepts a 24-bit RGB pixel stream over a valid/ready handshake, aligns it to start-of-frame, and generates linear write address, data and strobe into the image memory that the display-side image store reads during active drawing. Writes are held off whenever the display is drawing (HDraw & VDraw) so the memory port is never shared in the same cycle.

---
 rtl/img_loader.sv | 178 +++++++++++++++++
 tb/tb_img_loader.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/img_loader.sv
// img_loader: frame-store writer for the VGA image path.
//
// Takes a 24-bit RGB pixel stream on a valid/ready handshake, locks onto
// start-of-frame and emits one registered memory write per accepted pixel at
// linear address y*IMG_W+x. Writes are held off while the display is drawing
// (HDraw & VDraw) so the image memory port is never shared in one cycle.
//
// Optional feature: define IMG_LOADER_RGB565_EN to treat s_data[15:0] as
// RGB565 and expand it to RGB888 by MSB replication (s_data[23:16] ignored).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   HDraw, VDraw      active-draw flags from the timing generator
//   s_valid, s_ready  stream handshake
//   s_data, s_sof     pixel {R,G,B} and first-pixel-of-frame flag
//   wr_en, wr_addr,   registered memory write strobe, address, data
//   wr_data
//   busy              high while in the WRITE state
//   frame_done        one-cycle pulse when the last pixel is written
//   err_sof           one-cycle pulse when s_sof arrives mid-frame
module img_loader #(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              HDraw,
  input  logic              VDraw,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [23:0]       s_data,
  input  logic              s_sof,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err_sof
);

  localparam int unsigned Total = IMG_W * IMG_H;
  localparam int unsigned XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [23:0]       wr_data_q;
  logic              err_sof_q;

  logic        draw_active;
  logic        accept;
  logic        restart;
  logic        do_write;
  logic        sof_err;
  logic        last;
  logic [23:0] pix;

  // Pixel format conversion.
`ifdef IMG_LOADER_RGB565_EN
  logic [7:0] unused_hi;
  assign unused_hi = s_data[23:16];
  assign pix = {s_data[15:11], s_data[15:13],
                s_data[10:5],  s_data[10:9],
                s_data[4:0],   s_data[4:2]};
`else
  assign pix = s_data;
`endif

  assign draw_active = HDraw & VDraw;
  assign accept      = s_valid & s_ready;
  assign restart     = accept & s_sof;
  // In IDLE only an SOF beat is written; non-SOF beats are dropped.
  assign do_write    = accept & (s_sof | (state_q == StWrite));
  assign sof_err     = restart & (state_q == StWrite);
  assign last        = (cnt_q == ADDR_W'(Total - 1));

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (restart) state_d = (Total == 1) ? StDone : StWrite;
      end
      StWrite: begin
        if (restart)               state_d = (Total == 1) ? StDone : StWrite;
        else if (accept && last)   state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    s_ready    = !draw_active && (state_q != StDone);
    busy       = (state_q == StWrite);
    frame_done = (state_q == StDone);
  end

  // Counter next state. Counters only carry meaning while in WRITE; they are
  // cleared whenever we leave it so a new frame always starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    x_d   = x_q;
    y_d   = y_q;
    if (state_d != StWrite) begin
      cnt_d = '0;
      x_d   = '0;
      y_d   = '0;
    end else if (restart) begin
      cnt_d = ADDR_W'(1);
      x_d   = (IMG_W == 1) ? XW'(0) : XW'(1);
      y_d   = (IMG_W == 1) ? YW'(1) : YW'(0);
    end else if (do_write) begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (x_q == XW'(IMG_W - 1)) begin
        x_d = '0;
        y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_comb begin
    wr_addr_d = wr_addr_q;
    if (do_write) wr_addr_d = restart ? '0 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_sof_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      wr_en_q   <= do_write;
      wr_addr_q <= wr_addr_d;
      if (do_write) wr_data_q <= pix;
      err_sof_q <= sof_err;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign err_sof = err_sof_q;

`ifndef SYNTHESIS
  // The linear address counter must always agree with the x/y position.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (int'(x_q) + int'(y_q) * int'(IMG_W) == int'(cnt_q))
        else $error("img_loader x/y out of step with linear counter");
    end
  end
`endif

endmodule

// File: tb/tb_img_loader.sv
// Directed testbench for img_loader with a 4x3 image.
module tb_img_loader;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          HDraw, VDraw;
  logic          s_valid, s_ready, s_sof;
  logic [23:0]   s_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          busy, frame_done, err_sof;

  int n_cmp = 0;
  int n_err = 0;

  img_loader #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .HDraw      (HDraw),
    .VDraw      (VDraw),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_sof      (s_sof),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_done (frame_done),
    .err_sof    (err_sof)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_pix(input logic [23:0] d);
`ifdef IMG_LOADER_RGB565_EN
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
`else
    return d;
`endif
  endfunction

  // Present one beat, expect it to be accepted, then check the registered result.
  task automatic beat(input logic [23:0] d, input logic sof, input logic exp_we,
                      input int exp_addr, input logic exp_done, input logic exp_err,
                      input string tag);
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    #1;
    check({tag, ".ready"}, s_ready, 1);
    @(posedge clk); #1;
    check({tag, ".wr_en"}, wr_en, exp_we);
    if (exp_we) begin
      check({tag, ".addr"}, wr_addr, exp_addr);
      check({tag, ".data"}, wr_data, exp_pix(d));
    end
    check({tag, ".done"}, frame_done, exp_done);
    check({tag, ".err"}, err_sof, exp_err);
  endtask

  // Called while the FSM sits in DONE after the last pixel.
  task automatic end_frame(input string tag);
    check({tag, ".done_ready"}, s_ready, 0);
    check({tag, ".done_busy"}, busy, 0);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    @(posedge clk); #1;
    check({tag, ".idle_we"}, wr_en, 0);
    check({tag, ".idle_done"}, frame_done, 0);
    check({tag, ".idle_ready"}, s_ready, 1);
  endtask

  task automatic frame(input logic [23:0] base, input string tag);
    for (int i = 0; i < 12; i++)
      beat(base + 24'(i), i == 0, 1'b1, i, i == 11, 1'b0, tag);
    end_frame(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; HDraw = 1'b0; VDraw = 1'b0;
    s_valid = 1'b0; s_sof = 1'b0; s_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.wr_en", wr_en, 0);
    check("rst.addr", wr_addr, 0);
    check("rst.data", wr_data, 0);
    check("rst.busy", busy, 0);
    check("rst.done", frame_done, 0);
    check("rst.err", err_sof, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel.ready", s_ready, 1);

    // Back-to-back frame, data = index.
    frame(24'h0, "f1");

    // Non-SOF beats in IDLE are dropped.
    for (int i = 0; i < 3; i++) beat(24'hAAAAAA, 1'b0, 1'b0, 0, 1'b0, 1'b0, "drop");
    check("drop.busy", busy, 0);
    frame(24'h100, "f2");

    // Draw stall mid-frame, then HDraw alone must not stall.
    for (int i = 0; i < 4; i++) beat(24'h300 + 24'(i), i == 0, 1'b1, i, 1'b0, 1'b0, "st");
    HDraw = 1'b1; VDraw = 1'b1;
    s_valid = 1'b1; s_data = 24'h304; s_sof = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall.ready", s_ready, 0);
      @(posedge clk); #1;
      check("stall.wr_en", wr_en, 0);
      check("stall.busy", busy, 1);
    end
    VDraw = 1'b0;
    for (int i = 4; i < 8; i++) beat(24'h300 + 24'(i), 1'b0, 1'b1, i, 1'b0, 1'b0, "hd");
    HDraw = 1'b0;
    for (int i = 8; i < 12; i++) beat(24'h300 + 24'(i), 1'b0, 1'b1, i, i == 11, 1'b0, "st");
    end_frame("st");

    // SOF at pixel 5 restarts the frame.
    for (int i = 0; i < 5; i++) beat(24'h400 + 24'(i), i == 0, 1'b1, i, 1'b0, 1'b0, "re");
    beat(24'h500, 1'b1, 1'b1, 0, 1'b0, 1'b1, "re.sof");
    for (int k = 1; k < 12; k++) beat(24'h500 + 24'(k), 1'b0, 1'b1, k, k == 11, 1'b0, "re");
    end_frame("re");

    // Reset at pixel 7 abandons the frame.
    for (int i = 0; i < 7; i++) beat(24'h600 + 24'(i), i == 0, 1'b1, i, 1'b0, 1'b0, "rs");
    s_valid = 1'b0; s_sof = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rs.wr_en", wr_en, 0);
    check("rs.addr", wr_addr, 0);
    check("rs.data", wr_data, 0);
    check("rs.busy", busy, 0);
    check("rs.done", frame_done, 0);
    check("rs.err", err_sof, 0);
    rst = 1'b0;
    beat(24'h777, 1'b0, 1'b0, 0, 1'b0, 1'b0, "rs.drop");
    frame(24'h700, "f3");

`ifdef IMG_LOADER_RGB565_EN
    beat(24'h12F800, 1'b1, 1'b1, 0, 1'b0, 1'b0, "c565");
    check("c565.red", wr_data, 24'hFF0000);
    beat(24'h3407E0, 1'b0, 1'b1, 1, 1'b0, 1'b0, "c565");
    check("c565.green", wr_data, 24'h00FF00);
    beat(24'h560010, 1'b0, 1'b1, 2, 1'b0, 1'b0, "c565");
    check("c565.blue", wr_data, 24'h000084);
    for (int i = 3; i < 12; i++) beat(24'(i), 1'b0, 1'b1, i, i == 11, 1'b0, "c565");
    end_frame("c565");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
